serial_subtractor: RTL and testbench

Bit-serial subtractor computing `io_a - io_b - io_borrowIn` one bit per clock. It uses a single full-subtractor cell and a registered borrow, trading latency for area. It is the inverse-operation companion to the combinational ripple adder in the combinational-circuit library. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipelined producers and consumers.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrowIn using one full-subtractor cell; result valid WIDTH cycles after accept.
// A stalled consumer parks the block in DONE with the result held and no new operands accepted.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_borrowIn,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_diff,
    output logic             io_borrowOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_diff;
    logic             res_borrow;

    logic             load;
    logic             step;
    logic             last;
    logic             x;
    logic             y;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] acc_nxt;

    assign x    = a_sh[0];
    assign y    = b_sh[0];
    assign d    = x ^ y ^ br;
    assign bo   = (~x & y) | (~(x ^ y) & br);
    assign last = (cnt == CNT_LAST);

    // Shift right with d entering at the MSB; the concatenation form also covers WIDTH == 1.
    assign acc_nxt = WIDTH'({d, acc} >> 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        case (state)
            IDLE: begin
                io_in_ready = 1'b1;
                if (io_in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            res_diff   <= '0;
            res_borrow <= 1'b0;
        end else if (load) begin
            a_sh <= io_a;
            b_sh <= io_b;
            br   <= io_borrowIn;
            cnt  <= '0;
            acc  <= '0;
        end else if (step) begin
            acc  <= acc_nxt;
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
                res_diff   <= acc_nxt;
                res_borrow <= bo;
            end
        end
    end

    assign io_diff      = res_diff;
    assign io_borrowOut = res_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4: directed vectors plus an exhaustive sweep.
module tb_serial_subtractor;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bo;

    typedef struct packed {
        logic [3:0] d;
        logic       bo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (in_valid),
        .io_in_ready (in_ready),
        .io_a        (a),
        .io_b        (b),
        .io_borrowIn (bin),
        .io_out_valid(out_valid),
        .io_out_ready(out_ready),
        .io_diff     (diff),
        .io_borrowOut(bo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per completed output handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty_on_output", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_diff", diff, e.d);
                    check("result_borrow", bo, e.bo);
                end
            end
        end
    end

    // Issue one operation; returns at the negedge where out_valid is first seen, lat in cycles after accept.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                         input logic [3:0] ed, input logic ebo, output int lat);
        int w;
        exp_t e;
        w   = 0;
        lat = -1;
        @(negedge clock);
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        @(posedge clock);
        #1;
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clock);
        e.d  = ed;
        e.bo = ebo;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   lat;
        int   idx;
        int   prev;
        int   cyc;
        logic rdy;
        logic [3:0] bb_a  [5];
        logic [3:0] bb_b  [5];
        logic       bb_c  [5];
        logic [3:0] bb_d  [5];
        logic       bb_bo [5];

        bb_a[0] = 4'd6;  bb_b[0] = 4'd2; bb_c[0] = 1'b0; bb_d[0] = 4'd4;  bb_bo[0] = 1'b0;
        bb_a[1] = 4'd2;  bb_b[1] = 4'd6; bb_c[1] = 1'b0; bb_d[1] = 4'd12; bb_bo[1] = 1'b1;
        bb_a[2] = 4'd8;  bb_b[2] = 4'd8; bb_c[2] = 1'b1; bb_d[2] = 4'd15; bb_bo[2] = 1'b1;
        bb_a[3] = 4'd15; bb_b[3] = 4'd0; bb_c[3] = 1'b1; bb_d[3] = 4'd14; bb_bo[3] = 1'b0;
        bb_a[4] = 4'd7;  bb_b[4] = 4'd3; bb_c[4] = 1'b1; bb_d[4] = 4'd3;  bb_bo[4] = 1'b0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", bo, 0);

        // Basic subtract with latency and drain.
        out_ready = 1'b1;
        do_op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, lat);
        check("basic_latency", lat, 4);
        @(posedge clock);
        @(negedge clock);
        check("basic_drain_in_ready", in_ready, 1);

        // Underflow and edge vectors.
        do_op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, lat);
        do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, lat);
        do_op(4'd15, 4'd15, 1'b0, 4'h0, 1'b0, lat);

        // Back-pressure: result held, in_valid pulse ignored.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        do_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            in_valid = (i == 0);
            a        = 4'd1;
            b        = 4'd1;
            bin      = 1'b0;
            @(negedge clock);
            check("bp_out_valid", out_valid, 1);
            check("bp_diff", diff, 5);
            check("bp_borrow", bo, 0);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_no_capture_sb_empty", sb.size(), 0);

        // Reset during the second BUSY cycle.
        @(posedge clock);
        #1;
        a        = 4'd12;
        b        = 4'd7;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_diff", diff, 0);
        check("rst_mid_borrow", bo, 0);
        do_op(4'd12, 4'd7, 1'b0, 4'd5, 1'b0, lat);
        check("rst_after_latency", lat, 4);

        // Back-to-back with in_valid held high.
        @(posedge clock);
        #1;
        idx      = 0;
        prev     = -1;
        cyc      = 0;
        a        = bb_a[0];
        b        = bb_b[0];
        bin      = bb_c[0];
        in_valid = 1'b1;
        while (idx < 5 && cyc < 200) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            cyc++;
            if (rdy) begin
                exp_t e;
                e.d  = bb_d[idx];
                e.bo = bb_bo[idx];
                sb.push_back(e);
                if (prev >= 0) check("b2b_spacing", cyc - prev, 6);
                prev = cyc;
                idx++;
                #1;
                if (idx < 5) begin
                    a   = bb_a[idx];
                    b   = bb_b[idx];
                    bin = bb_c[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        #1;
        in_valid = 1'b0;
        check("b2b_accepts", idx, 5);
        repeat (10) @(posedge clock);

        // Exhaustive sweep against the arithmetic model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [3:0] md;
                    logic       mb;
                    md = 4'(ia - ib - ic);
                    mb = (ia < ib + ic);
                    do_op(4'(ia), 4'(ib), ic[0], md, mb, lat);
                end
            end
        end

        repeat (10) @(posedge clock);
        @(negedge clock);
        check("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
